cpu_hazard_ctrl: RTL
====================

Name: cpu_hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the accelerator CPU: the next generation of the existing combinational stall logic. It tracks in-flight destination registers in an internal shift-register scoreboard and raises a read-after-write stall when a decode-stage source matches. An optional forwarding mode replaces stalls with bypass selects, leaving only load-use stalls. A counter-based jump/branch stall and a saturating stall-cycle performance counter complete the block; it sits beside the decode stage.

Parameters:
NUM_REGS, 16, architectural register count; REG_W = $clog2(NUM_REGS) localparam
PIPE_DEPTH, 3, stages tracked after decode (EX..WB-1); entry 0 is youngest
JB_FLUSH_CYCLES, 2, stall cycles after a jump/branch issues; 0 disables
FWD_EN, 0, 1 = forwarding mode (stall only on load-use)
ZERO_REG_HW, 0, 1 = register 0 never causes a hazard

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
id_valid  in  1  decode holds a valid instruction
id_src_a / id_src_b  in  REG_W  source registers
id_src_a_en / id_src_b_en  in  1  source actually read
id_dst  in  REG_W  destination register
id_dst_en  in  1  instruction writes a register
id_is_load  in  1  result available only after MEM
id_is_jb  in  1  jump/branch instruction
br_resolve  in  1  EX resolved the branch; ends jb stall early
flush  in  1  kill stage-0 entry and decode issue this cycle
rw_stall  out  1  data-hazard stall
jb_stall  out  1  control-hazard stall
stall  out  1  rw_stall | jb_stall
fwd_a / fwd_b  out  $clog2(PIPE_DEPTH+1)  0 = register file, k = entry k-1
stall_cnt  out  16  saturating count of stalled valid cycles

Behaviour:
- Reset (rst=1 at a clk edge): all entry valids 0, jb counter 0, stall_cnt 0. Next cycle: rw_stall=0, jb_stall=0, stall=0, fwd_a=fwd_b=0.
- Entry fields: {valid, dst, is_load}. issue = id_valid & ~stall & ~flush.
- Each clk: entry[0] <= issue & id_dst_en ? {1,id_dst,id_is_load} : bubble (valid=0); entry[i] <= entry[i-1]. Entries retire off the end after PIPE_DEPTH cycles.
- flush: entry[0] invalidated (the bubble shifted in next cycle also suppresses it), issue suppressed, jb counter cleared. Older entries are unaffected.
- Match(src) = src_en & entry[i].valid & entry[i].dst==src & !(ZERO_REG_HW & src==0). Youngest matching entry (lowest i) wins.
- FWD_EN=0: rw_stall = id_valid & any match on A or B; fwd_a=fwd_b=0 always.
- FWD_EN=1: fwd_x = (youngest match index)+1, else 0. rw_stall = id_valid & youngest match is entry 0 with is_load=1. fwd outputs are still driven during a stall.
- rw_stall, stall and fwd are combinational from the current entries and ID inputs; 0-cycle latency.
- jb: if id_valid & id_is_jb & ~stall & ~flush, counter <= JB_FLUSH_CYCLES. jb_stall = counter!=0; the counter decrements each cycle while nonzero. br_resolve or flush sets the counter to 0 at the next edge. br_resolve with a new jb issue in the same cycle: the load wins.
- stall_cnt increments when stall & id_valid; it holds at 16'hFFFF.
- Reset mid-operation discards all entries; no stale stall is permitted after reset.

Test Plan:
- FWD_EN=0. Issue dst=R5, next cycle src_a=R5 -> rw_stall=1 for 3 cycles (entries 0,1,2), released on cycle 4. stall_cnt=3.
- FWD_EN=1. ALU dst=R3 then src_b=R3 -> no stall, fwd_b=1. After one bubble -> fwd_b=2.
- FWD_EN=1. Load dst=R7 then src_a=R7 -> rw_stall=1 for exactly 1 cycle, then fwd_a=2.
- Two writers R4 in entries 0 and 2, reader R4, FWD_EN=1 -> fwd_a=1 (youngest). ZERO_REG_HW=1 with R0 -> no stall.
- jb issue -> jb_stall=1 for 2 cycles. Repeat with br_resolve on the first stall cycle -> jb_stall=1 for 1 cycle. Flush during jb stall -> jb_stall=0 next cycle.
- Force 70000 stall cycles -> stall_cnt=16'hFFFF. Assert rst mid-hazard -> all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/cpu_hazard_ctrl.sv
// Decode-side hazard controller: scoreboard of in-flight destinations, RAW stall or
// bypass select, counter-based jump/branch stall and a saturating stall-cycle counter.

module cpu_hazard_match #(
  parameter int REG_W       = 4,
  parameter int ZERO_REG_HW = 0
) (
  input  logic             valid,
  input  logic [REG_W-1:0] dst,
  input  logic [REG_W-1:0] src,
  input  logic             src_en,
  output logic             hit
);
  assign hit = src_en & valid & (dst == src) & ~((ZERO_REG_HW != 0) && (src == '0));
endmodule

module cpu_hazard_ctrl #(
  parameter int NUM_REGS        = 16,
  parameter int PIPE_DEPTH      = 3,
  parameter int JB_FLUSH_CYCLES = 2,
  parameter int FWD_EN          = 0,
  parameter int ZERO_REG_HW     = 0,
  localparam int REG_W          = $clog2(NUM_REGS),
  localparam int FW_W           = $clog2(PIPE_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src_a,
  input  logic [REG_W-1:0] id_src_b,
  input  logic             id_src_a_en,
  input  logic             id_src_b_en,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_dst_en,
  input  logic             id_is_load,
  input  logic             id_is_jb,
  input  logic             br_resolve,
  input  logic             flush,
  output logic             rw_stall,
  output logic             jb_stall,
  output logic             stall,
  output logic [FW_W-1:0]  fwd_a,
  output logic [FW_W-1:0]  fwd_b,
  output logic [15:0]      stall_cnt
);
  localparam bit FWD_MODE = (FWD_EN != 0);
  localparam int JB_W = (JB_FLUSH_CYCLES > 0) ? $clog2(JB_FLUSH_CYCLES + 1) : 1;
  localparam logic [JB_W-1:0] JB_LOAD = JB_W'(JB_FLUSH_CYCLES);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
  } entry_t;

  entry_t [PIPE_DEPTH-1:0] ent;
  // Only the youngest entry's load flag can ever cause a load-use stall.
  logic                    ld0;
  logic [PIPE_DEPTH-1:0]   hit_a, hit_b;
  logic [FW_W-1:0]         idx_a, idx_b;
  logic [JB_W-1:0]         jb_cnt;
  logic                    issue, load_use;

  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_ent
    cpu_hazard_match #(.REG_W(REG_W), .ZERO_REG_HW(ZERO_REG_HW)) u_ma (
      .valid(ent[g].valid), .dst(ent[g].dst), .src(id_src_a), .src_en(id_src_a_en), .hit(hit_a[g]));
    cpu_hazard_match #(.REG_W(REG_W), .ZERO_REG_HW(ZERO_REG_HW)) u_mb (
      .valid(ent[g].valid), .dst(ent[g].dst), .src(id_src_b), .src_en(id_src_b_en), .hit(hit_b[g]));
  end

  // Scan oldest to youngest so the youngest hit overwrites.
  always_comb begin
    idx_a = '0;
    idx_b = '0;
    for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
      if (hit_a[i]) idx_a = FW_W'(i + 1);
      if (hit_b[i]) idx_b = FW_W'(i + 1);
    end
  end

  assign load_use = (hit_a[0] | hit_b[0]) & ld0;
  assign rw_stall = id_valid & (FWD_MODE ? load_use : ((|hit_a) | (|hit_b)));
  assign jb_stall = (jb_cnt != '0);
  assign stall    = rw_stall | jb_stall;
  assign fwd_a    = FWD_MODE ? idx_a : '0;
  assign fwd_b    = FWD_MODE ? idx_b : '0;
  assign issue    = id_valid & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent <= '0;
      ld0 <= 1'b0;
    end else begin
      ent[0].valid <= issue & id_dst_en;
      ent[0].dst   <= id_dst;
      ld0          <= issue & id_dst_en & id_is_load;
      // flush kills the instruction currently in stage 0 as it moves on
      for (int i = 1; i < PIPE_DEPTH; i++)
        ent[i] <= (i == 1 && flush) ? '0 : ent[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                       jb_cnt <= '0;
    else if (issue && id_is_jb)    jb_cnt <= JB_LOAD;
    else if (br_resolve || flush)  jb_cnt <= '0;
    else if (jb_cnt != '0)         jb_cnt <= jb_cnt - JB_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                                   stall_cnt <= '0;
    else if (stall && id_valid && !(&stall_cnt)) stall_cnt <= stall_cnt + 16'd1;
  end
endmodule
